// File: rtl/fetch_align_ctrl.sv
// RV32IC fetch sequencer: word reads from imem, halfword queue,
// one 16/32-bit instruction per handshake, redirect flush.
module fetch_align_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        is_compressed
);

    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic [15:0] hw_q [3];
    logic [15:0] hw_d [3];
    logic [31:0] pc_q [3];
    logic [31:0] pc_d [3];
    logic [1:0]  cnt_q, cnt_d;
    logic        outstanding_q, outstanding_d;
    logic        discard_q, discard_d;
    logic        skip_low_q, skip_low_d;

    logic        head_c;
    logic        head_ok;
    logic        pop;
    logic [1:0]  pop_n;
    logic [1:0]  cnt_ap;
    logic [1:0]  idx1;
    logic        rsp;
    logic        keep;

    assign head_c  = (hw_q[0][1:0] != 2'b11);
    assign head_ok = head_c ? (cnt_q != 2'd0) : (cnt_q >= 2'd2);

    assign inst_valid    = head_ok & ~redirect;
    assign is_compressed = inst_valid & head_c;
    assign pc_out        = pc_q[0];

    always_comb begin
        inst_out = 32'h0;
        if (inst_valid) begin
            if (head_c) inst_out = {16'h0, hw_q[0]};
            else        inst_out = {hw_q[1], hw_q[0]};
        end
    end

    assign pop    = inst_valid & inst_ready;
    assign pop_n  = pop ? (head_c ? 2'd1 : 2'd2) : 2'd0;
    assign cnt_ap = cnt_q - pop_n;
    assign idx1   = cnt_ap + 2'd1;

    // Only one read in flight and a refill only below two entries,
    // so a two-halfword push always fits in the three-entry queue.
    assign imem_req  = ~reset & ~redirect & ~outstanding_q
                     & (cnt_ap <= 2'd1);
    assign imem_addr = fetch_addr_q;

    assign rsp  = imem_rvalid & outstanding_q;
    assign keep = rsp & ~discard_q & ~redirect;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            hw_d[i] = hw_q[i];
            pc_d[i] = pc_q[i];
        end
        fetch_addr_d  = fetch_addr_q;
        cnt_d         = cnt_ap;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        skip_low_d    = skip_low_q;

        unique case (pop_n)
            2'd1: begin
                hw_d[0] = hw_q[1];
                pc_d[0] = pc_q[1];
                hw_d[1] = hw_q[2];
                pc_d[1] = pc_q[2];
            end
            2'd2: begin
                hw_d[0] = hw_q[2];
                pc_d[0] = pc_q[2];
            end
            default: ;
        endcase

        if (redirect) begin
            cnt_d         = 2'd0;
            fetch_addr_d  = {redirect_pc[31:2], 2'b00};
            skip_low_d    = redirect_pc[1];
            discard_d     = outstanding_q & ~imem_rvalid;
            outstanding_d = outstanding_q & ~imem_rvalid;
        end else begin
            if (rsp) begin
                outstanding_d = 1'b0;
                discard_d     = 1'b0;
            end
            if (keep) begin
                fetch_addr_d = fetch_addr_q + 32'd4;
                skip_low_d   = 1'b0;
                if (skip_low_q) begin
                    hw_d[cnt_ap] = imem_rdata[31:16];
                    pc_d[cnt_ap] = fetch_addr_q + 32'd2;
                    cnt_d        = cnt_ap + 2'd1;
                end else begin
                    hw_d[cnt_ap] = imem_rdata[15:0];
                    pc_d[cnt_ap] = fetch_addr_q;
                    hw_d[idx1]   = imem_rdata[31:16];
                    pc_d[idx1]   = fetch_addr_q + 32'd2;
                    cnt_d        = cnt_ap + 2'd2;
                end
            end
            if (imem_req) outstanding_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_addr_q  <= RESET_PC;
            cnt_q         <= 2'd0;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            skip_low_q    <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                hw_q[i] <= 16'h0;
                pc_q[i] <= 32'h0;
            end
        end else begin
            fetch_addr_q  <= fetch_addr_d;
            cnt_q         <= cnt_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            skip_low_q    <= skip_low_d;
            for (int i = 0; i < 3; i++) begin
                hw_q[i] <= hw_d[i];
                pc_q[i] <= pc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fetch_align_ctrl.sv
// Directed bench for fetch_align_ctrl: reset fetch, compressed pairs,
// straddling 32-bit, redirects, decode stall.
module tb_fetch_align_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        is_compressed;

    int n_checks = 0;
    int n_errors = 0;

    fetch_align_ctrl #(.RESET_PC(32'h0000_0100)) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_out      (inst_out),
        .pc_out        (pc_out),
        .is_compressed (is_compressed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_inst(input string tag, input logic [31:0] ins,
                            input logic [31:0] pc, input logic c);
        chk({tag, "_valid"}, inst_valid, 1);
        chk({tag, "_inst"}, inst_out, ins);
        chk({tag, "_pc"}, pc_out, pc);
        chk({tag, "_c"}, is_compressed, c);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 32'h100);
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", inst_out, 0);
        chk("rst_c", is_compressed, 0);
        chk("rst_pc", pc_out, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk("fetch_req", imem_req, 1);
        chk("fetch_addr", imem_addr, a);
        @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        #1;
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1;
    endtask

    initial begin
        inst_ready = 1'b1;

        // 1: reset fetch of a 32-bit instruction
        do_reset();
        chk("t1_req", imem_req, 1);
        chk("t1_addr", imem_addr, 32'h100);
        do_fetch(32'h100, 32'h0000_0013);
        chk_inst("t1", 32'h13, 32'h100, 0);

        // 2: two compressed halves of one word
        do_reset();
        do_fetch(32'h100, 32'h4505_4501);
        chk_inst("t2a", 32'h4501, 32'h100, 1);
        @(negedge clk); #1;
        chk_inst("t2b", 32'h4505, 32'h102, 1);

        // 3: 32-bit instruction straddling a word boundary
        do_reset();
        do_fetch(32'h100, 32'h0013_4501);
        chk_inst("t3a", 32'h4501, 32'h100, 1);
        chk("t3_req", imem_req, 1);
        chk("t3_addr", imem_addr, 32'h104);
        @(negedge clk); #1;
        chk("t3_wait0", inst_valid, 0);
        @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h4505_0000;
        #1;
        chk("t3_wait1", inst_valid, 0);
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1;
        chk_inst("t3b", 32'h13, 32'h102, 0);
        @(negedge clk); #1;
        chk_inst("t3c", 32'h4505, 32'h106, 1);

        // 4: redirect while the read at 0x104 is in flight
        do_reset();
        do_fetch(32'h100, 32'h4505_4501);
        chk("t4_req104", imem_req, 1);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h202;
        #1;
        chk("t4_rd_valid", inst_valid, 0);
        chk("t4_rd_req", imem_req, 0);
        @(negedge clk);
        redirect    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_0013;
        #1;
        chk("t4_stale_req", imem_req, 0);
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1;
        chk("t4_drop_valid", inst_valid, 0);
        do_fetch(32'h200, 32'h4505_ABCD);
        chk_inst("t4", 32'h4505, 32'h202, 1);

        // 5: decode stall with two halfwords buffered
        inst_ready = 1'b0;
        do_reset();
        do_fetch(32'h100, 32'h4505_4501);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk_inst("t5_hold", 32'h4501, 32'h100, 1);
            chk("t5_hold_req", imem_req, 0);
        end
        @(negedge clk);
        inst_ready = 1'b1;
        #1;
        chk_inst("t5a", 32'h4501, 32'h100, 1);
        chk("t5_req", imem_req, 1);
        @(negedge clk); #1;
        chk_inst("t5b", 32'h4505, 32'h102, 1);

        // 6: redirect in the same cycle as the response
        do_reset();
        chk("t6_req", imem_req, 1);
        @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h4505_4501;
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        #1;
        chk("t6_rd_valid", inst_valid, 0);
        @(negedge clk);
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        #1;
        chk("t6_drop_valid", inst_valid, 0);
        chk("t6_req2", imem_req, 1);
        chk("t6_addr2", imem_addr, 32'h300);
        do_fetch(32'h300, 32'h4505_4501);
        chk_inst("t6", 32'h4501, 32'h300, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
